seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/seven_seg_hex_rom.sv | 38 +++
 rtl/seven_seg_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns and
// blanking values.  Patterns are active-low, ordered {A,B,C,D,E,F,G}, A = MSB.
// Latency: n/a (constants only).  Backpressure: n/a.
package seven_seg_pkg;

   // Decimal glyphs
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;

   // Hex glyphs (A, b, C, d, E, F)
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;

   // A blanked digit and a fully dark bus are the same pattern; the two names
   // keep "digit intentionally blank" distinct from "display switched off".
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_OFF   = 7'h7F;

endpackage

// File: rtl/seven_seg_hex_rom.sv
// Nibble to active-low segment pattern decoder; hex glyphs optional.
// Latency: combinational.  Backpressure: none.
// Ports: i_nibble (value 0..15), i_hex_en (1: show A-F for 10..15, 0: blank),
//        o_seg_n ({A..G}, active-low).
module seven_seg_hex_rom
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_hex_en,
   output logic [6:0] o_seg_n
);

   always_comb begin
      o_seg_n = SEG_BLANK;
      case (i_nibble)
         4'h0:    o_seg_n = SEG_0;
         4'h1:    o_seg_n = SEG_1;
         4'h2:    o_seg_n = SEG_2;
         4'h3:    o_seg_n = SEG_3;
         4'h4:    o_seg_n = SEG_4;
         4'h5:    o_seg_n = SEG_5;
         4'h6:    o_seg_n = SEG_6;
         4'h7:    o_seg_n = SEG_7;
         4'h8:    o_seg_n = SEG_8;
         4'h9:    o_seg_n = SEG_9;
         // Non-decimal nibbles only get a glyph in hex mode; in BCD mode they
         // render as blank so a corrupted BCD digit is visibly empty.
         4'hA:    o_seg_n = i_hex_en ? SEG_A : SEG_BLANK;
         4'hB:    o_seg_n = i_hex_en ? SEG_B : SEG_BLANK;
         4'hC:    o_seg_n = i_hex_en ? SEG_C : SEG_BLANK;
         4'hD:    o_seg_n = i_hex_en ? SEG_D : SEG_BLANK;
         4'hE:    o_seg_n = i_hex_en ? SEG_E : SEG_BLANK;
         4'hF:    o_seg_n = i_hex_en ? SEG_F : SEG_BLANK;
         default: o_seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned double buffer.
// Latency: outputs registered, 1 clk behind scan index / active buffer.
// Backpressure: none; load is a fire-and-forget strobe, last load before a frame wins.
// Ports: clk/reset (sync, active-high); enable (scan run/dark); load + value/dp_in
//        (packed nibbles, digit 0 rightmost); blank_lz (leading-zero blanking);
//        seg_n/dp_n/an_n (active-low pins); frame (1-clk pulse after index wrap).
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int HEX_EN      = 1
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [DIV_W-1:0]        r_div_cnt;
   logic [IDX_W-1:0]        r_dig_idx;

   logic [4*NUM_DIGITS-1:0] r_act_val;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [4*NUM_DIGITS-1:0] r_pend_val;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic                    r_pend_v;

   logic [6:0]              r_seg_n;
   logic                    r_dp_n;
   logic [NUM_DIGITS-1:0]   r_an_n;
   logic                    r_frame;

   // ---------------------------------------------------------------------
   // Scan timing
   // ---------------------------------------------------------------------
   logic w_tick;
   logic w_wrap;
   logic w_commit;

   assign w_tick = (r_div_cnt == DIV_LAST) & enable;
   assign w_wrap = w_tick & (r_dig_idx == IDX_LAST);

   // The buffer may be swapped at a frame boundary, or at any time while the
   // display is dark since nothing is being scanned that could tear.
   assign w_commit = w_wrap | ~enable;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt <= '0;
         r_dig_idx <= '0;
      end else if (enable) begin
         if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end

         if (w_tick) begin
            if (r_dig_idx == IDX_LAST) begin
               r_dig_idx <= '0;
            end else begin
               r_dig_idx <= r_dig_idx + IDX_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Double buffer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_act_val  <= '0;
         r_act_dp   <= '0;
         r_pend_val <= '0;
         r_pend_dp  <= '0;
         r_pend_v   <= 1'b0;
      end else if (w_commit) begin
         // A load landing on the commit cycle bypasses the pending stage so
         // it is not held back a whole extra frame.
         if (load) begin
            r_act_val <= value;
            r_act_dp  <= dp_in;
         end else if (r_pend_v) begin
            r_act_val <= r_pend_val;
            r_act_dp  <= r_pend_dp;
         end
         r_pend_v <= 1'b0;
      end else if (load) begin
         r_pend_val <= value;
         r_pend_dp  <= dp_in;
         r_pend_v   <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Current digit select, leading-zero detect, anode pattern
   // ---------------------------------------------------------------------
   logic [3:0]            w_nib;
   logic                  w_dp;
   logic                  w_lz_cur;
   logic                  w_zero_run;
   logic [NUM_DIGITS-1:0] w_an_sel;

   // Walk from the most significant digit down: a digit is a leading zero
   // while every nibble from the top down to it is zero. Digit 0 is exempt so
   // a zero value still shows a single "0".
   always_comb begin
      w_nib      = 4'h0;
      w_dp       = 1'b0;
      w_lz_cur   = 1'b0;
      w_zero_run = 1'b1;
      w_an_sel   = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run & (r_act_val[4*i +: 4] == 4'h0);
         if (r_dig_idx == IDX_W'(i)) begin
            w_nib       = r_act_val[4*i +: 4];
            w_dp        = r_act_dp[i];
            w_lz_cur    = blank_lz & w_zero_run & (i != 0);
            w_an_sel[i] = 1'b0;
         end
      end
   end

   logic [6:0] w_rom_seg;

   seven_seg_hex_rom u_rom (
      .i_nibble (w_nib),
      .i_hex_en (HEX_EN != 0),
      .o_seg_n  (w_rom_seg)
   );

   // ---------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg_n <= SEG_OFF;
         r_dp_n  <= 1'b1;
         r_an_n  <= '1;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_wrap;
         if (!enable) begin
            r_seg_n <= SEG_OFF;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
         end else begin
            r_seg_n <= w_lz_cur ? SEG_BLANK : w_rom_seg;
            // Decimal point is independent of leading-zero blanking.
            r_dp_n  <= ~w_dp;
            // Anodes go dark for the one clock in which the index advances so
            // the previous digit's segments never ghost onto the next anode.
            r_an_n  <= w_tick ? '1 : w_an_sel;
         end
      end
   end

   assign seg_n = r_seg_n;
   assign dp_n  = r_dp_n;
   assign an_n  = r_an_n;
   assign frame = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b0100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SB = 7'b1100000;
   localparam logic [6:0] SC = 7'b0110001;
   localparam logic [6:0] SD = 7'b1000010;
   localparam logic [6:0] SX = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset, enable, load, blank_lz;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [6:0]  seg_n, seg_n2;
   logic        dp_n, dp_n2, frame, frame2;
   logic [3:0]  an_n, an_n2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n),
      .an_n(an_n), .frame(frame)
   );

   seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(0)) dut_nohex (
      .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg_n(seg_n2), .dp_n(dp_n2),
      .an_n(an_n2), .frame(frame2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance to the first cycle digit d is lit; return what both DUTs show.
   task automatic wait_digit(input int d, output logic [6:0] seg,
                             output logic dp, output logic [6:0] seg2);
      logic [3:0] tgt;
      int n;
      tgt = ~(4'b0001 << d);
      n = 0;
      step();
      while (an_n !== tgt && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (an_n !== tgt) begin
         failures++;
         $display("FAIL wait_digit%0d: an_n=%b required %b", d, an_n, tgt);
      end
      seg  = seg_n;
      dp   = dp_n;
      seg2 = seg_n2;
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      step();
      while (frame !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (frame !== 1'b1) begin
         failures++;
         $display("FAIL wait_frame: frame=%b required 1", frame);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_an;
      reset = 1'b1; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
      value = 16'h0; dp_in = 4'h0;
      step();
      step();
      checks++; if (seg_n !== 7'h7F) begin failures++; $display("FAIL reset_seg: seg_n=%b required 1111111", seg_n); end
      checks++; if (dp_n !== 1'b1)   begin failures++; $display("FAIL reset_dp: dp_n=%b required 1", dp_n); end
      checks++; if (an_n !== 4'hF)   begin failures++; $display("FAIL reset_an: an_n=%b required 1111", an_n); end
      checks++; if (frame !== 1'b0)  begin failures++; $display("FAIL reset_frame: frame=%b required 0", frame); end
      reset = 1'b0; enable = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
         exp_an = (k % 4 == 0) ? 4'hF : ~(4'b0001 << (((k - 1) / 4) % 4));
         checks++;
         if (an_n !== exp_an) begin
            failures++; $display("FAIL scan_an cyc%0d: an_n=%b required %b", k, an_n, exp_an);
         end
         if (exp_an != 4'hF) begin
            checks++;
            if (seg_n !== S0) begin
               failures++; $display("FAIL scan_seg cyc%0d: seg_n=%b required %b", k, seg_n, S0);
            end
         end
         checks++;
         if (frame !== (k == 16)) begin
            failures++; $display("FAIL scan_frame cyc%0d: frame=%b required %b", k, frame, (k == 16));
         end
      end
   endtask

   task automatic test_load_mid_frame();
      logic [6:0] s, s2;
      logic dp;
      logic [6:0] exp [4];
      int n;
      exp[0] = S4; exp[1] = S3; exp[2] = S2; exp[3] = S1;
      wait_digit(1, s, dp, s2);
      value = 16'h1234; load = 1'b1;
      step();
      load = 1'b0;
      n = 0;
      while (frame !== 1'b1 && n < 40) begin
         if (an_n !== 4'hF) begin
            checks++;
            if (seg_n !== S0) begin
               failures++; $display("FAIL premature_load: seg_n=%b required %b", seg_n, S0);
            end
         end
         step();
         n++;
      end
      checks++;
      if (frame !== 1'b1) begin failures++; $display("FAIL load_frame: frame=%b required 1", frame); end
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, s, dp, s2);
         checks++;
         if (s !== exp[d]) begin
            failures++; $display("FAIL load_1234 d%0d: seg_n=%b required %b", d, s, exp[d]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] s, s2;
      logic dp;
      logic [6:0] exp [4];
      wait_digit(1, s, dp, s2);
      value = 16'h1111; load = 1'b1;
      step();
      value = 16'h2222;
      step();
      load = 1'b0;
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, s, dp, s2);
         checks++;
         if (s !== S2) begin
            failures++; $display("FAIL last_wins d%0d: seg_n=%b required %b", d, s, S2);
         end
      end
      // now on the first lit cycle of digit 3; the wrap edge is 3 clocks away
      step();
      step();
      value = 16'h5678; load = 1'b1;
      step();
      load = 1'b0;
      checks++;
      if (frame !== 1'b1) begin failures++; $display("FAIL boundary_frame: frame=%b required 1", frame); end
      exp[0] = S8; exp[1] = S7; exp[2] = S6; exp[3] = S5;
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, s, dp, s2);
         checks++;
         if (s !== exp[d]) begin
            failures++; $display("FAIL boundary_load d%0d: seg_n=%b required %b", d, s, exp[d]);
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [6:0] s, s2;
      logic dp;
      logic [6:0] exp [4];
      logic [3:0] exp_dp;
      blank_lz = 1'b1;
      value = 16'h0050; dp_in = 4'b0100; load = 1'b1;
      step();
      load = 1'b0;
      wait_frame();
      exp[0] = S0; exp[1] = S5; exp[2] = SX; exp[3] = SX;
      exp_dp = 4'b1011;
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, s, dp, s2);
         checks++;
         if (s !== exp[d]) begin
            failures++; $display("FAIL lz_0050 d%0d: seg_n=%b required %b", d, s, exp[d]);
         end
         checks++;
         if (dp !== exp_dp[d]) begin
            failures++; $display("FAIL lz_dp d%0d: dp_n=%b required %b", d, dp, exp_dp[d]);
         end
      end
      value = 16'h0000; dp_in = 4'b1000; load = 1'b1;
      step();
      load = 1'b0;
      wait_frame();
      exp[0] = S0; exp[1] = SX; exp[2] = SX; exp[3] = SX;
      exp_dp = 4'b0111;
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, s, dp, s2);
         checks++;
         if (s !== exp[d]) begin
            failures++; $display("FAIL lz_0000 d%0d: seg_n=%b required %b", d, s, exp[d]);
         end
         checks++;
         if (dp !== exp_dp[d]) begin
            failures++; $display("FAIL lz0_dp d%0d: dp_n=%b required %b", d, dp, exp_dp[d]);
         end
      end
      blank_lz = 1'b0; dp_in = 4'b0000;
   endtask

   task automatic test_hex();
      logic [6:0] s, s2;
      logic dp;
      logic [6:0] exp [4];
      value = 16'hABCD; load = 1'b1;
      step();
      load = 1'b0;
      wait_frame();
      exp[0] = SD; exp[1] = SC; exp[2] = SB; exp[3] = SA;
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, s, dp, s2);
         checks++;
         if (s !== exp[d]) begin
            failures++; $display("FAIL hex d%0d: seg_n=%b required %b", d, s, exp[d]);
         end
         checks++;
         if (s2 !== SX) begin
            failures++; $display("FAIL nohex d%0d: seg_n=%b required %b", d, s2, SX);
         end
      end
   endtask

   task automatic test_enable();
      logic [6:0] s, s2;
      logic dp;
      wait_digit(1, s, dp, s2);
      step();
      enable = 1'b0;
      value = 16'h0990; load = 1'b1;
      step();
      load = 1'b0;
      checks++; if (an_n !== 4'hF)  begin failures++; $display("FAIL dis_an: an_n=%b required 1111", an_n); end
      checks++; if (seg_n !== 7'h7F) begin failures++; $display("FAIL dis_seg: seg_n=%b required 1111111", seg_n); end
      checks++; if (dp_n !== 1'b1)   begin failures++; $display("FAIL dis_dp: dp_n=%b required 1", dp_n); end
      for (int k = 0; k < 8; k++) step();
      checks++; if (an_n !== 4'hF)  begin failures++; $display("FAIL dis_hold_an: an_n=%b required 1111", an_n); end
      enable = 1'b1;
      step();
      checks++; if (an_n !== 4'b1101) begin failures++; $display("FAIL reen_an: an_n=%b required 1101", an_n); end
      checks++; if (seg_n !== S9)     begin failures++; $display("FAIL reen_seg: seg_n=%b required %b", seg_n, S9); end
      step();
      checks++; if (an_n !== 4'hF)    begin failures++; $display("FAIL reen_gap: an_n=%b required 1111", an_n); end
      step();
      checks++; if (an_n !== 4'b1011) begin failures++; $display("FAIL reen_next: an_n=%b required 1011", an_n); end
      checks++; if (seg_n !== S9)     begin failures++; $display("FAIL reen_next_seg: seg_n=%b required %b", seg_n, S9); end
   endtask

   task automatic test_reset_pending();
      logic [6:0] s, s2;
      logic dp;
      wait_digit(1, s, dp, s2);
      value = 16'h7777; load = 1'b1;
      step();
      load = 1'b0;
      reset = 1'b1;
      step();
      step();
      checks++; if (an_n !== 4'hF)   begin failures++; $display("FAIL rst_an: an_n=%b required 1111", an_n); end
      checks++; if (seg_n !== 7'h7F) begin failures++; $display("FAIL rst_seg: seg_n=%b required 1111111", seg_n); end
      checks++; if (frame !== 1'b0)  begin failures++; $display("FAIL rst_frame: frame=%b required 0", frame); end
      reset = 1'b0;
      step();
      checks++; if (an_n !== 4'b1110) begin failures++; $display("FAIL rst_first_an: an_n=%b required 1110", an_n); end
      checks++; if (seg_n !== S0)     begin failures++; $display("FAIL rst_first_seg: seg_n=%b required %b", seg_n, S0); end
      wait_frame();
      for (int d = 0; d < 4; d++) begin
         wait_digit(d, s, dp, s2);
         checks++;
         if (s !== S0) begin
            failures++; $display("FAIL rst_pending d%0d: seg_n=%b required %b", d, s, S0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_mid_frame();
      test_back_to_back();
      test_leading_zero();
      test_hex();
      test_enable();
      test_reset_pending();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
